mul_seq: RTL and testbench

- Sequential unsigned shift-and-add multiplier; the arithmetic inverse of the combinational divider in the ALU datapath.
- Same result/overflow presentation as the divider: 16-bit result plus overflow flag. Also exposes the upper product half so the ALU can build a full 32-bit product.
- Iterative multi-cycle design, so the ALU sequencer drives it with a start/busy/done handshake.

---
 rtl/mul_seq_pkg.sv | 13 +
 rtl/mul_step.sv | 24 ++
 rtl/mul_seq.sv | 105 ++++++++++
 tb/tb_mul_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared ALU constants for the sequential multiplier: default operand width
// and the controller state encoding.
package mul_seq_pkg;

  localparam int MUL_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_step.sv
// One shift-and-add iteration: conditionally add mcand into the upper half of
// the partial product, then shift {carry, P} right by one bit.
import mul_seq_pkg::*;

module mul_step #(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic [2*WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH-1:0] p_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, p_i[2*WIDTH-1:WIDTH]};
    if (p_i[0]) begin
      sum = sum + {1'b0, mcand_i};
    end
    // The add carry lands in the top product bit after the shift.
    p_o = {sum, p_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential unsigned shift-and-add multiplier with start/busy/done handshake.
// Fixed latency of WIDTH iterations; registered low/high product halves.
//
// state | meaning
// IDLE  | waiting for start, outputs hold last product
// RUN   | one add/shift per cycle, count walks WIDTH down to 1
// DONE  | done pulse for one cycle; start here begins the next operation
import mul_seq_pkg::*;

module mul_seq #(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] product_hi,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mul_state_e         state_q, state_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   result_q, product_hi_q;
  logic               overflow_q;
  logic               load_out;
  logic [2*WIDTH-1:0] p_step;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .p_i     (p_q),
    .mcand_i (mcand_q),
    .p_o     (p_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      mcand_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      mcand_q <= mcand_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    mcand_d  = mcand_q;
    count_d  = count_q;
    load_out = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // DONE accepts start exactly like IDLE for gapless back-to-back ops.
        if (start) begin
          mcand_d = multiplicand;
          p_d     = {{WIDTH{1'b0}}, multiplier};
          count_d = CNT_W'(WIDTH);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        p_d     = p_step;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d  = DONE;
          load_out = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output halves are captured from the final iteration on the edge into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q     <= '0;
      product_hi_q <= '0;
      overflow_q   <= 1'b0;
    end else if (load_out) begin
      result_q     <= p_step[WIDTH-1:0];
      product_hi_q <= p_step[2*WIDTH-1:WIDTH];
      overflow_q   <= |p_step[2*WIDTH-1:WIDTH];
    end
  end

  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign result     = result_q;
  assign product_hi = product_hi_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: directed handshake scenarios plus random operands,
// checked against a plain A*B reference product.
module tb_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] product_hi;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  mul_seq #(.WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .product_hi   (product_hi),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_product(input string tag, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] prod;
    prod = 32'(a) * 32'(b);
    check({tag, " result"}, 32'(result), 32'(prod[15:0]));
    check({tag, " product_hi"}, 32'(product_hi), 32'(prod[31:16]));
    check({tag, " overflow"}, 32'(overflow), 32'(prod[31:16] != 16'h0));
  endtask

  // Starts one operation, optionally pokes start with 7*7 while busy, and
  // returns at the negedge of the done cycle after checking latency.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int poke);
    int n;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    multiplicand = $urandom;
    multiplier = $urandom;
    busy_cnt = 0;
    seen = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (n == poke) begin
        start = 1'b1;
        multiplicand = 16'd7;
        multiplier = 16'd7;
      end else if (n == poke + 1) begin
        start = 1'b0;
      end
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(n), 32'd17);
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'd16);
    check({tag, " busy at done"}, 32'(busy), 32'd0);
    check_product(tag, a, b);
  endtask

  initial begin
    int n;
    int pulses;
    bit seen;
    logic [15:0] ra, rb;

    rst_n = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset product_hi", 32'(product_hi), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    run_op("basic 3x5", 16'd3, 16'd5, 0);
    run_op("ovf 100x100", 16'h0100, 16'h0100, 0);
    run_op("ovf ffffxffff", 16'hFFFF, 16'hFFFF, 0);
    run_op("zero 0xffff", 16'h0000, 16'hFFFF, 0);
    run_op("ignore start", 16'd5, 16'd6, 5);

    // Hold: outputs stable, no done without a new start.
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("hold no activity", 32'(pulses), 32'd0);
    check_product("hold", 16'd5, 16'd6);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1;
    multiplicand = 16'd2;
    multiplier = 16'd9;
    seen = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b first done", 32'(seen), 32'd1);
    check("b2b first latency", 32'(n), 32'd17);
    check_product("b2b first", 16'd2, 16'd9);
    multiplicand = 16'd4;
    multiplier = 16'd4;
    @(negedge clk);
    check("b2b no gap busy", 32'(busy), 32'd1);
    start = 1'b0;
    multiplicand = 16'hDEAD;
    multiplier = 16'hBEEF;
    seen = 1'b0;
    for (n = 2; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b second done", 32'(seen), 32'd1);
    check("b2b second latency", 32'(n), 32'd17);
    check_product("b2b second", 16'd4, 16'd4);

    // Reset mid-operation.
    @(negedge clk);
    start = 1'b1;
    multiplicand = 16'h1234;
    multiplier = 16'h0010;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst result", 32'(result), 32'd0);
    check("midrst product_hi", 32'(product_hi), 32'd0);
    check("midrst overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst no done", 32'(pulses), 32'd0);
    run_op("after reset", 16'h1234, 16'h0010, 0);

    // Random operands.
    for (int k = 0; k < 20; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k == 0) ra = 16'h0000;
      if (k == 1) rb = 16'h0001;
      run_op($sformatf("rand%0d %h x %h", k, ra, rb), ra, rb, (k % 3 == 0) ? 9 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
